reg_file: RTL and testbench
===========================

Name: reg_file

Overview:
- 32-entry general-purpose register file for the single-cycle MIPS datapath.
- Sits directly upstream of the ALU:
  - rd_data1 drives the ALU scrA input.
  - rd_data2 drives scrB, through the ALUSrc immediate mux outside this block.
- Two combinational read ports and one synchronous write port.
- Register $0 is hardwired to zero.
- The write port is fed from the write-back mux (ALU_result or memory read data).

Parameters:
- DATA_W, 32, width of each register and of the data ports.
- ADDR_W, 5, register address width.
- NUM_REGS, 32, number of architectural registers; must equal 2**ADDR_W.

Ports:
- clk  input  1  single clock; all state updates on its rising edge
- rst_n  input  1  asynchronous, active-low reset
- rd_addr1  input  ADDR_W  read port 1 address (instruction rs field)
- rd_addr2  input  ADDR_W  read port 2 address (instruction rt field)
- rd_data1  output  DATA_W  read port 1 data, to ALU scrA
- rd_data2  output  DATA_W  read port 2 data, to ALUSrc mux / data memory write data
- reg_write  input  1  write enable from main control
- wr_addr  input  ADDR_W  write address (rt or rd, chosen by the RegDst mux)
- wr_data  input  DATA_W  write-back data

Behaviour:
- Clocking and reset:
  - One clock, clk. Reset is asynchronous and active-low on rst_n.
  - While rst_n=0, entries 1..NUM_REGS-1 are forced to 0 immediately, regardless of clk.
  - Consequently rd_data1 = rd_data2 = 0 for every address during reset.
  - A write attempted in the same cycle as reset is discarded.
  - Reset asserted mid-operation overrides any pending write.
  - After rst_n deasserts, the first rising edge may write.
- Read ports:
  - Purely combinational. rd_dataN = regs[rd_addrN], with zero-cycle latency.
  - No clock or enable is involved.
- Register $0:
  - Address 0 always reads 0.
  - Writes to address 0 are ignored: no storage is updated and no side effect occurs.
- Write port:
  - On the rising edge of clk with rst_n=1 and reg_write=1 and wr_addr!=0, regs[wr_addr] <= wr_data.
  - The new value is visible on the read ports after that edge.
  - With reg_write=0, no register changes.
- Read-during-write, same address, base build:
  - The read returns the OLD value until the edge.
  - After the edge it returns the new value.
- Both read ports may address the same register. Both then return identical data.
- Width rules:
  - No arithmetic is performed.
  - wr_data is stored full-width DATA_W.
- X-handling: an unknown wr_addr with reg_write=1 must not corrupt $0.

Optional Feature:
- Macro: REGFILE_BYPASS_EN.
- Defined:
  - Each read port compares its address against wr_addr.
  - If reg_write=1 and rd_addrN==wr_addr and wr_addr!=0, rd_dataN returns wr_data combinationally, i.e. write-through forwarding.
  - This is for a future pipelined variant where write-back and decode share a cycle.
  - Address 0 still reads 0.
- Undefined: base behaviour; the old value is read until the edge.

Decomposition:
- Shared package mips_pkg:
  - Constants DATA_W=32, ADDR_W=5, NUM_REGS=32, and REG_ZERO=5'd0.
  - Typedefs word_t (logic [31:0]) and reg_addr_t (logic [4:0]).
- No sub-module required.
- The read-port logic (mux plus optional bypass) is duplicated per port. It may be factored as reg_file_rd_port if the bypass grows.

Test Plan:
- Reset: drive rst_n=0 mid-run after writing regs[5]=32'hDEADBEEF -> rd_data1 with rd_addr1=5 reads 0 immediately, with no clock edge needed.
- Basic write/read: reg_write=1, wr_addr=8, wr_data=32'd500, then wr_addr=9, wr_data=32'd300 -> rd_addr1=8, rd_addr2=9 give 500 and 300. Feeding the ALU with ALU_control=3'b010 yields ALU_result=800.
- $0 protection: reg_write=1, wr_addr=0, wr_data=32'hFFFFFFFF, clock -> rd_addr1=0 reads 0. All other registers are unchanged.
- Write disabled: reg_write=0, wr_addr=10, wr_data=32'd7, clock -> regs[10] keeps its prior value (0 after reset).
- Read-during-write: regs[12]=32'd10. Set reg_write=1, wr_addr=12, wr_data=32'd100, rd_addr1=12.
  - Before the edge, rd_data1=10 (base) or 100 (REGFILE_BYPASS_EN).
  - After the edge, rd_data1=100 in both builds.
- Dual-port alias: rd_addr1=rd_addr2=12 -> both outputs equal 100. Feeding the ALU with ALU_control=3'b110 gives zero_F=1.

Source files
------------

// File: rtl/mips_pkg.sv
// mips_pkg: shared datapath widths, register-file constants and word/address types
package mips_pkg;
    localparam int DATA_W   = 32;
    localparam int ADDR_W   = 5;
    localparam int NUM_REGS = 32;
    localparam logic [4:0] REG_ZERO = 5'd0;
    typedef logic [31:0] word_t;
    typedef logic [4:0]  reg_addr_t;
endpackage

// File: rtl/reg_file.sv
// reg_file: 32-entry MIPS register file, two combinational read ports, one synchronous write port, $0 hardwired to zero.
// Build option: define REGFILE_BYPASS_EN to forward a same-cycle write to the read ports (write-through).
module reg_file
    import mips_pkg::*;
#(
    parameter int DATA_W   = mips_pkg::DATA_W,
    parameter int ADDR_W   = mips_pkg::ADDR_W,
    parameter int NUM_REGS = mips_pkg::NUM_REGS
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ADDR_W-1:0] rd_addr1,
    input  logic [ADDR_W-1:0] rd_addr2,
    output logic [DATA_W-1:0] rd_data1,
    output logic [DATA_W-1:0] rd_data2,
    input  logic              reg_write,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data
);
    logic [DATA_W-1:0] regs_q [NUM_REGS];
    logic              wr_en;

    // An unknown or zero address never qualifies, so entry 0 stays at its reset value of zero.
    assign wr_en = reg_write && (wr_addr != '0);

    // Register array: cleared asynchronously, written on the rising edge when enabled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < NUM_REGS; k++) regs_q[k] <= '0;
        end else if (wr_en) begin
            regs_q[wr_addr] <= wr_data;
        end
    end

    // Read port 1: address 0 reads zero; optional forwarding of the in-flight write.
    always_comb begin
        rd_data1 = (rd_addr1 == '0) ? '0 : regs_q[rd_addr1];
`ifdef REGFILE_BYPASS_EN
        if (wr_en && (rd_addr1 == wr_addr)) rd_data1 = wr_data;
`endif
    end

    // Read port 2: same structure as port 1.
    always_comb begin
        rd_data2 = (rd_addr2 == '0) ? '0 : regs_q[rd_addr2];
`ifdef REGFILE_BYPASS_EN
        if (wr_en && (rd_addr2 == wr_addr)) rd_data2 = wr_data;
`endif
    end
endmodule

// File: tb/tb_reg_file.sv
// tb_reg_file: directed self-checking bench for reg_file (base build or REGFILE_BYPASS_EN).
module tb_reg_file;
    import mips_pkg::*;

    logic      clk = 1'b0;
    logic      rst_n = 1'b0;
    reg_addr_t rd_addr1 = '0;
    reg_addr_t rd_addr2 = '0;
    word_t     rd_data1;
    word_t     rd_data2;
    logic      reg_write = 1'b0;
    reg_addr_t wr_addr = '0;
    word_t     wr_data = '0;
    int        n_cmp = 0;
    int        n_bad = 0;

    reg_file dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .rd_addr1  (rd_addr1),
        .rd_addr2  (rd_addr2),
        .rd_data1  (rd_data1),
        .rd_data2  (rd_data2),
        .reg_write (reg_write),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input word_t got, input word_t exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic write(input reg_addr_t a, input word_t d);
        reg_write = 1'b1;
        wr_addr   = a;
        wr_data   = d;
        tick();
        reg_write = 1'b0;
    endtask

    task automatic read(input reg_addr_t a1, input reg_addr_t a2);
        rd_addr1 = a1;
        rd_addr2 = a2;
        #1;
    endtask

    initial begin
        @(negedge clk);
        read(5'd5, 5'd31);
        check("reset_rd1", rd_data1, 32'd0);
        check("reset_rd2", rd_data2, 32'd0);
        rst_n = 1'b1;
        write(5'd5, 32'hDEADBEEF);
        read(5'd5, 5'd0);
        check("write5", rd_data1, 32'hDEADBEEF);
        rst_n = 1'b0;
        #1;
        check("async_reset", rd_data1, 32'd0);
        write(5'd6, 32'h12345678);
        rst_n = 1'b1;
        read(5'd6, 5'd5);
        check("write_in_reset", rd_data1, 32'd0);
        check("reset_cleared5", rd_data2, 32'd0);
        write(5'd8, 32'd500);
        write(5'd9, 32'd300);
        read(5'd8, 5'd9);
        check("rd8", rd_data1, 32'd500);
        check("rd9", rd_data2, 32'd300);
        check("alu_add", rd_data1 + rd_data2, 32'd800);
        write(5'd0, 32'hFFFFFFFF);
        read(5'd0, 5'd8);
        check("zero_reg", rd_data1, 32'd0);
        check("zero_no_side", rd_data2, 32'd500);
        reg_write = 1'b0;
        wr_addr   = 5'd10;
        wr_data   = 32'd7;
        tick();
        read(5'd10, 5'd9);
        check("wr_disabled", rd_data1, 32'd0);
        check("wr_disabled9", rd_data2, 32'd300);
        write(5'd12, 32'd10);
        reg_write = 1'b1;
        wr_addr   = 5'd12;
        wr_data   = 32'd100;
        read(5'd12, 5'd9);
`ifdef REGFILE_BYPASS_EN
        check("rdw_before", rd_data1, 32'd100);
`else
        check("rdw_before", rd_data1, 32'd10);
`endif
        tick();
        reg_write = 1'b0;
        #1;
        check("rdw_after", rd_data1, 32'd100);
        read(5'd12, 5'd12);
        check("alias1", rd_data1, 32'd100);
        check("alias2", rd_data2, 32'd100);
        check("alu_sub_zero", {31'd0, (rd_data1 - rd_data2) == 32'd0}, 32'd1);
        reg_write = 1'b1;
        wr_addr   = 5'd0;
        wr_data   = 32'hA5A5A5A5;
        read(5'd0, 5'd0);
        check("zero_during_wr", rd_data1, 32'd0);
        tick();
        reg_write = 1'b0;
        write(5'd31, 32'hCAFEF00D);
        read(5'd31, 5'd12);
        check("rd31", rd_data1, 32'hCAFEF00D);
        check("rd12_kept", rd_data2, 32'd100);
        reg_write = 1'b1;
        wr_addr   = 'x;
        wr_data   = 32'hFFFFFFFF;
        tick();
        reg_write = 1'b0;
        wr_addr   = '0;
        read(5'd0, 5'd0);
        check("x_addr_zero", rd_data1, 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
